// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared constants, state type and helpers for the text console writer
// Purpose: screen geometry, control-code values and the console FSM state type,
//          shared by text_console_writer and its testbench.
// Ports:   none (package)
package text_console_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_FF    = 8'h0C;

    typedef enum logic [1:0] {
        CLEAR,
        LINE_CLEAR,
        IDLE
    } state_e;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_cell_addr.sv
// rtl/text_cell_addr.sv - combinational (row, col) to text buffer cell index
// Purpose: addr = row*80 + col using shifts and adds only.
// Ports:   row_i  - row 0..59
//          col_i  - column or fill offset (full ADDR_W so a linear fill index can pass through with row 0)
//          addr_o - cell index
module text_cell_addr #(
    parameter int ADDR_W = 13
) (
    input  logic [5:0]        row_i,
    input  logic [ADDR_W-1:0] col_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] row_w;

    assign row_w  = ADDR_W'(row_i);
    // row*80 = row*64 + row*16
    assign addr_o = (row_w << 6) + (row_w << 4) + col_i;

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - character-stream console controller driving the VGA text buffer write port
// Purpose: accepts characters over valid/ready, tracks the cursor, handles LF/CR/BS/FF and
//          sequences full-screen and single-line clears into the 80x60 text buffer.
// Ports:   clk, rst (async, active low)
//          char_valid/char_ready/char_data/char_rgb - producer handshake
//          clear_req - full-screen clear request (sampled in IDLE), busy - full clear running
//          ascii_write_en/ascii_input/ascii_write_address - registered buffer write port
//          cursor_col/cursor_row - current cursor position
module text_console_writer #(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 60,
    parameter int          ADDR_W      = 13,
    parameter logic [23:0] DEFAULT_RGB = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic [7:0]        char_data,
    input  logic [23:0]       char_rgb,
    input  logic              clear_req,
    output logic              busy,
    output logic              ascii_write_en,
    output logic [31:0]       ascii_input,
    output logic [ADDR_W-1:0] ascii_write_address,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row
);

    import text_console_pkg::*;

    localparam logic [31:0] FILL_WORD = {ASCII_SPACE, DEFAULT_RGB};
    localparam int          LAST_CELL = COLS * ROWS - 1;

    state_e            state_q;
    logic [ADDR_W-1:0] fill_cnt_q;
    logic [6:0]        col_q;
    logic [5:0]        row_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;

    logic [5:0]        mux_row;
    logic [ADDR_W-1:0] mux_col;
    logic [ADDR_W-1:0] cell_addr;
    logic [5:0]        row_next;

    assign char_ready          = (state_q == IDLE) && !clear_req;
    assign busy                = (state_q == CLEAR);
    assign ascii_write_en      = we_q;
    assign ascii_write_address = addr_q;
    assign ascii_input         = data_q;
    assign cursor_col          = col_q;
    assign cursor_row          = row_q;

    assign row_next = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;

    // Single address generator: full clear walks the linear index with row 0,
    // line clear walks the current row, IDLE targets the cursor (or the cell left of it for BS).
    always_comb begin
        mux_row = row_q;
        mux_col = ADDR_W'(col_q);
        case (state_q)
            CLEAR: begin
                mux_row = 6'd0;
                mux_col = fill_cnt_q;
            end
            LINE_CLEAR: mux_col = fill_cnt_q;
            default: begin
                if (char_data == ASCII_BS) begin
                    mux_col = ADDR_W'(col_q - 7'd1);
                end
            end
        endcase
    end

    text_cell_addr #(
        .ADDR_W (ADDR_W)
    ) u_cell_addr (
        .row_i  (mux_row),
        .col_i  (mux_col),
        .addr_o (cell_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            fill_cnt_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= FILL_WORD;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    we_q   <= 1'b1;
                    addr_q <= cell_addr;
                    data_q <= FILL_WORD;
                    col_q  <= '0;
                    row_q  <= '0;
                    if (fill_cnt_q == ADDR_W'(LAST_CELL)) begin
                        fill_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end
                LINE_CLEAR: begin
                    we_q   <= 1'b1;
                    addr_q <= cell_addr;
                    data_q <= FILL_WORD;
                    if (fill_cnt_q == ADDR_W'(COLS - 1)) begin
                        fill_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                    end
                end
                default: begin
                    // clear_req wins over a simultaneous character (char_ready is low then)
                    if (clear_req) begin
                        state_q    <= CLEAR;
                        fill_cnt_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                    end else if (char_valid) begin
                        if (is_printable(char_data)) begin
                            we_q   <= 1'b1;
                            addr_q <= cell_addr;
                            data_q <= {char_data, char_rgb};
                            if (col_q == 7'(COLS - 1)) begin
                                col_q      <= '0;
                                row_q      <= row_next;
                                fill_cnt_q <= '0;
                                state_q    <= LINE_CLEAR;
                            end else begin
                                col_q <= col_q + 7'd1;
                            end
                        end else begin
                            case (char_data)
                                ASCII_LF: begin
                                    col_q      <= '0;
                                    row_q      <= row_next;
                                    fill_cnt_q <= '0;
                                    state_q    <= LINE_CLEAR;
                                end
                                ASCII_CR: col_q <= '0;
                                ASCII_BS: begin
                                    if (col_q != 7'd0) begin
                                        col_q  <= col_q - 7'd1;
                                        we_q   <= 1'b1;
                                        addr_q <= cell_addr;
                                        data_q <= FILL_WORD;
                                    end
                                end
                                ASCII_FF: begin
                                    state_q    <= CLEAR;
                                    fill_cnt_q <= '0;
                                    col_q      <= '0;
                                    row_q      <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Character-stream console controller that owns the write port of `ascii_master_controller`'s 80x60 text buffer. It accepts characters from a producer (CPU store path or debug source) over a valid/ready handshake, tracks a cursor, and handles control codes. It sequences the multi-cycle fills: full-screen clear, line clear on newline/wrap, and backspace. It sits between the producer and the `ascii_write_en` / `ascii_input` / `ascii_write_address` inputs of the VGA text controller.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 60, rows per screen
- `ADDR_W`, 13, buffer address width
- `DEFAULT_RGB`, 24'hFFFFFF, colour used for clear/backspace fills
- `clk`  in  1  system clock (CLOCK_50)
- `rst`  in  1  asynchronous active-low reset
- `char_valid`  in  1  producer has a character
- `char_ready`  out  1  block accepts a character this cycle
- `char_data`  in  8  ASCII code
- `char_rgb`  in  24  colour for printable characters
- `clear_req`  in  1  request a full-screen clear, sampled in IDLE
- `busy`  out  1  a clear sequence is in progress
- `ascii_write_en`  out  1  buffer write strobe
- `ascii_input`  out  32  {ascii[31:24], rgb[23:0]}
- `ascii_write_address`  out  ADDR_W  cell index = row*COLS + col
- `cursor_col`  out  7  current column, 0..79
- `cursor_row`  out  6  current row, 0..59

## Operation
- States: CLEAR (full screen), LINE_CLEAR (one row), IDLE.
- `char_ready` = (state==IDLE) && !clear_req. It is combinational from registered state.
- A character is accepted on a clock edge where `char_valid && char_ready`.
- Printable (0x20–0x7E):
  - Write {char_data, char_rgb} at (row, col).
  - If col<79: col+1.
  - Else: col=0, row=row+1 (59 wraps to 0), then enter LINE_CLEAR for the new row.
- 0x0A LF: col=0, row+1 (with wrap), enter LINE_CLEAR. No character write.
- 0x0D CR: col=0. No write.
- 0x08 BS:
  - If col>0: col-1, write {0x20, DEFAULT_RGB} at the new position.
  - If col==0: no-op.
- 0x0C FF: same as `clear_req`.
- All other codes: accepted and discarded.
- CLEAR:
  - Writes {0x20, DEFAULT_RGB} to addresses 0..4799 in ascending order, one per cycle.
  - Cursor is forced to (0,0).
  - `busy`=1 throughout.
- LINE_CLEAR: writes {0x20, DEFAULT_RGB} to row*80+0 .. row*80+79, one per cycle.
- There is no scroll; the buffer is write-only.
- `clear_req` in IDLE takes priority over a simultaneous `char_valid`: the character is not accepted.
- `clear_req` outside IDLE is ignored; it is not queued.
- Address arithmetic: (row<<6)+(row<<4)+col, computed at ADDR_W bits. The maximum is 4799, so there is no overflow.

## Timing
- Reset values:
  - `ascii_write_en`=0, `ascii_write_address`=0, `ascii_input`={0x20, DEFAULT_RGB}
  - cursor=(0,0), state=CLEAR, `busy`=1, `char_ready`=0
- After reset release, CLEAR starts immediately.
- All write outputs are registered. `ascii_write_en` is high for exactly one cycle per write.
- Printable character or backspace accepted at edge N: the write is visible in cycle N+1. The cursor is updated in cycle N+1.
- Back-to-back printable characters (no wrap) sustain one write per cycle. `char_ready` stays high.
- LF accepted at edge N: state=LINE_CLEAR in N+1; clear writes visible N+2..N+81; IDLE and `char_ready`=1 in N+81.
- Printable at col 79 accepted at edge N: character write visible N+1; line-clear writes N+2..N+81; IDLE in N+81.
- Full clear (reset, `clear_req`, or FF) entered at edge N: writes visible N+2..N+4801; `busy` drops and IDLE begins in N+4801.
- Reset asserted mid-sequence: all state and outputs return to reset values asynchronously, and a full CLEAR restarts from address 0.

## Structure
- Shared package `text_console_pkg` holds:
  - COLS, ROWS, CELLS=4800
  - ASCII_SPACE/LF/CR/BS/FF constants
  - the state enum {CLEAR, LINE_CLEAR, IDLE}
- One sub-module, `text_cell_addr`: combinational (row, col) -> address using shift-add, no multiplier. It is instantiated once, fed by a mux of the cursor and the clear counter.
- The fill counter is 13 bits, shared by CLEAR and LINE_CLEAR.

## Test plan
- Reset, then release -> 4800 writes, addresses 0..4799, data 0x20FFFFFF. `busy` falls and `char_ready` rises the cycle after the 4800th write.
- Stream "AB" with rgb 0x00FF00 -> writes {0x41,0x00FF00}@0 and {0x42,0x00FF00}@1 on consecutive cycles; cursor ends at (0,2).
- LF at (0,5) -> cursor (1,0); 80 space writes at 80..159; `char_ready` low for exactly 80 cycles.
- 80 printable characters from (59,0) -> last write @4799; cursor wraps to (0,0); line clear at 0..79.
- BS at (3,0) -> no write. BS at (3,4) -> space written @243, cursor (3,3).
- `clear_req` and `char_valid` asserted together in IDLE -> character not accepted; full CLEAR runs. Reset pulsed at fill address 2000 -> restart from 0.
